// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a bounded grant hold time.
// A release always passes through one idle cycle before the next owner is picked.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  // state    | meaning
  // ST_IDLE  | no grant; arbitrate among req when en=1
  // ST_GRANT | gnt_idx owns the grant; hold_q counts its cycles
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] gnt_q, gnt_d;

  logic       pick_found;
  logic [1:0] pick_idx;
  logic [1:0] cand;
  logic       release_c;

  // Walk the search order backwards so the lowest offset from ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign release_c = !en || !req[idx_q] || (hold_q == HOLD_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      hold_q  <= 8'd0;
      idx_q   <= 2'd0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en && pick_found) state_d = ST_GRANT;
      ST_GRANT: if (release_c)        state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d  = ptr_q;
    hold_d = hold_q;
    idx_d  = idx_q;
    gnt_d  = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (en && pick_found) begin
          idx_d  = pick_idx;
          hold_d = 8'd1;
          gnt_d  = 4'b0001 << pick_idx;
        end else begin
          hold_d = 8'd0;
          gnt_d  = 4'b0000;
        end
      end
      ST_GRANT: begin
        if (release_c) begin
          ptr_d  = idx_q + 2'd1;
          hold_d = 8'd0;
          gnt_d  = 4'b0000;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        hold_d = 8'd0;
        gnt_d  = 4'b0000;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == ST_GRANT);

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: MAX_HOLD=8 instance plus a MAX_HOLD=1 instance
// sharing the same stimulus; outputs sampled on the falling edge.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;

  logic [3:0] gnt, gnt1;
  logic [1:0] idx, idx1;
  logic       vld, vld1;

  int  total = 0;
  int  bad = 0;
  bit  mon_on = 1'b0;
  int  run0 = 0;
  int  run1 = 0;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt), .gnt_idx(idx), .gnt_valid(vld)
  );

  rr_arbiter_4 #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(vld1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_g(input string tag, input logic [3:0] g, input logic [1:0] i,
                          input logic v);
    check_val({tag, ".gnt"}, 32'(gnt), 32'(g));
    check_val({tag, ".idx"}, 32'(idx), 32'(i));
    check_val({tag, ".vld"}, 32'(vld), 32'(v));
  endtask

  // Continuous invariants: zero/one-hot, decode consistency, hold bound.
  always @(negedge clk) begin
    if (mon_on) begin
      check_val("onehot0", 32'($onehot0(gnt)), 32'd1);
      check_val("gnt_dec", 32'(gnt), vld ? 32'(4'b0001 << idx) : 32'd0);
      run0 = (gnt != 4'b0000) ? run0 + 1 : 0;
      check_val("maxhold8", 32'(run0 <= 8), 32'd1);
      check_val("onehot0_h1", 32'($onehot0(gnt1)), 32'd1);
      run1 = (gnt1 != 4'b0000) ? run1 + 1 : 0;
      check_val("maxhold1", 32'(run1 <= 1), 32'd1);
    end
  end

  initial begin
    logic [1:0] oi;
    rst_n = 1'b0; en = 1'b0; req = 4'b0000;
    repeat (2) step();
    rst_n = 1'b1;
    mon_on = 1'b1;
    expect_g("reset", 4'b0000, 2'd0, 1'b0);

    en = 1'b1; req = 4'b0000;
    step(); expect_g("idle_noreq", 4'b0000, 2'd0, 1'b0);

    // Full rotation under continuous request
    req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      oi = 2'(o);
      for (int c = 0; c < 8; c++) begin
        step(); expect_g("rot", 4'b0001 << oi, oi, 1'b1);
      end
      step(); expect_g("rot_gap", 4'b0000, oi, 1'b0);
    end
    req = 4'b0000;
    step(); expect_g("idle_keep_idx", 4'b0000, 2'd0, 1'b0);

    // Single requester for three cycles; ptr is 1 so owner 2 is found
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step(); expect_g("single", 4'b0100, 2'd2, 1'b1);
      if (c == 2) req = 4'b0000;
    end
    step(); expect_g("single_rel", 4'b0000, 2'd2, 1'b0);
    step(); expect_g("single_idle", 4'b0000, 2'd2, 1'b0);

    // ptr=3: owner 3 first, then wrap to 0
    req = 4'b1001;
    step(); expect_g("wrap3_a", 4'b1000, 2'd3, 1'b1);
    step(); expect_g("wrap3_b", 4'b1000, 2'd3, 1'b1);
    req = 4'b0001;
    step(); expect_g("wrap3_rel", 4'b0000, 2'd3, 1'b0);
    step(); expect_g("wrap0", 4'b0001, 2'd0, 1'b1);

    // Non-owner request changes are ignored during a grant
    req = 4'b1111;
    step(); expect_g("other_req_a", 4'b0001, 2'd0, 1'b1);
    req = 4'b0011;
    step(); expect_g("other_req_b", 4'b0001, 2'd0, 1'b1);

    // Enable dropped mid-grant, then held low with full request
    en = 1'b0;
    step(); expect_g("en_drop", 4'b0000, 2'd0, 1'b0);
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step(); expect_g("en_low", 4'b0000, 2'd0, 1'b0);
    end
    en = 1'b1;
    step(); expect_g("en_ptr_adv", 4'b0010, 2'd1, 1'b1);

    // Reset mid-grant discards the owner
    rst_n = 1'b0;
    step(); expect_g("rst_mid", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1; req = 4'b0011;
    step(); expect_g("rst_prio", 4'b0001, 2'd0, 1'b1);

    // Owner drops req on the same cycle the hold limit is reached
    for (int c = 2; c <= 8; c++) begin
      step(); expect_g("hold_run", 4'b0001, 2'd0, 1'b1);
    end
    req = 4'b1110;
    step(); expect_g("dual_rel", 4'b0000, 2'd0, 1'b0);
    step(); expect_g("dual_next", 4'b0010, 2'd1, 1'b1);
    req = 4'b0000;
    step(); expect_g("dual_done", 4'b0000, 2'd1, 1'b0);
    step(); expect_g("dual_idle", 4'b0000, 2'd1, 1'b0);

    // MAX_HOLD=1: one-cycle grants separated by one idle cycle
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; en = 1'b1; req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      oi = 2'(o);
      step();
      check_val("h1.gnt", 32'(gnt1), 32'(4'b0001 << oi));
      check_val("h1.idx", 32'(idx1), 32'(oi));
      check_val("h1.vld", 32'(vld1), 32'd1);
      step();
      check_val("h1.gap", 32'(gnt1), 32'd0);
      check_val("h1.gapv", 32'(vld1), 32'd0);
    end

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
